// File: rtl/block_memory_responder.sv
// rtl/block_memory_responder.sv - main-memory responder: fixed-latency block read, single-word write
module block_memory_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BLK_W   = 2,
  parameter int LATENCY = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [BLK_W-1:0]  o_word_idx,
  output logic              o_ready
);

  // Latency counter only needs to hold LATENCY-1
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [BLK_W-1:0]    r_wcnt;
  logic [BLK_W-1:0]    w_wcnt_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic                w_wait_done;
  logic                w_commit;
  logic                w_busy_nxt;
  logic                w_rvalid_nxt;
  logic                w_ready_nxt;
  logic [BLK_W-1:0]    w_idx_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic [ADDR_W-1:0]   w_raddr;

  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_commit    = w_wait_done && r_we;

  // State register; reset abandons any request in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_nxt = r_we ? S_DONE : S_BURST;
      S_BURST: if (r_wcnt == '1) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word counter: zero entering the burst, wraps after the last word
  always_comb begin
    w_wcnt_nxt = '0;
    if (r_state == S_BURST) w_wcnt_nxt = r_wcnt + 1'b1;
  end

  // Request capture and latency/word counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_wcnt <= w_wcnt_nxt;
      if (r_state == S_IDLE && i_start) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Storage array has no reset so contents survive rst_n
  always_ff @(posedge i_clk) begin
    if (w_commit) r_mem[r_addr] <= r_wdata;
  end

  // Burst always walks the aligned block from word 0
  assign w_raddr = {r_addr[ADDR_W-1:BLK_W], w_wcnt_nxt};

  // Output decode for the coming state; registered below
  always_comb begin
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_rvalid_nxt = (w_state_nxt == S_BURST);
    w_ready_nxt  = (w_state_nxt == S_DONE);
    w_idx_nxt    = '0;
    w_rdata_nxt  = '0;
    if (w_rvalid_nxt) begin
      w_idx_nxt   = w_wcnt_nxt;
      w_rdata_nxt = r_mem[w_raddr];
    end
  end

  // Registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy     <= 1'b0;
      o_rvalid   <= 1'b0;
      o_ready    <= 1'b0;
      o_word_idx <= '0;
      o_rdata    <= '0;
    end else begin
      o_busy     <= w_busy_nxt;
      o_rvalid   <= w_rvalid_nxt;
      o_ready    <= w_ready_nxt;
      o_word_idx <= w_idx_nxt;
      o_rdata    <= w_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_block_memory_responder.sv
// tb/tb_block_memory_responder.sv - randomized self-checking bench for block_memory_responder
module tb_block_memory_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        start_s [2];
  logic        we_s    [2];
  logic [9:0]  addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        busy_o  [2];
  logic        rvalid_o[2];
  logic        ready_o [2];
  logic [1:0]  widx_o  [2];
  logic [31:0] rdata_o [2];

  // reference memory contents per instance
  logic [31:0] mem_m [2][1024];

  int n_checks = 0;
  int n_errors = 0;

  block_memory_responder #(.ADDR_W(10), .DATA_W(32), .BLK_W(2), .LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_s[0]), .i_start(start_s[0]), .i_we(we_s[0]),
    .i_addr(addr_s[0]), .i_wdata(wdata_s[0]), .o_busy(busy_o[0]), .o_rvalid(rvalid_o[0]),
    .o_rdata(rdata_o[0]), .o_word_idx(widx_o[0]), .o_ready(ready_o[0]));

  block_memory_responder #(.ADDR_W(10), .DATA_W(32), .BLK_W(2), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_s[1]), .i_start(start_s[1]), .i_we(we_s[1]),
    .i_addr(addr_s[1]), .i_wdata(wdata_s[1]), .o_busy(busy_o[1]), .o_rvalid(rvalid_o[1]),
    .o_rdata(rdata_o[1]), .o_word_idx(widx_o[1]), .o_ready(ready_o[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int d);
    return {27'b0, busy_o[d], rvalid_o[d], ready_o[d], widx_o[d], rdata_o[d]};
  endfunction

  function automatic logic [63:0] pack(input bit busy, input bit rv, input bit rdy,
                                       input logic [1:0] idx, input logic [31:0] data);
    return {27'b0, busy, rv, rdy, idx, data};
  endfunction

  // One request, checked cycle by cycle from the protocol timing rules
  task automatic do_req(input int d, input bit we, input logic [9:0] a,
                        input logic [31:0] wd, input bit inj);
    int lat;
    int total;
    logic [31:0] blk [4];
    logic [9:0]  wa;
    bit busy, rv, rdy;
    logic [1:0]  idx;
    logic [31:0] data;
    lat   = (d == 0) ? 4 : 1;
    total = we ? lat + 1 : lat + 5;
    for (int w = 0; w < 4; w++) begin
      wa = {a[9:2], 2'(w)};
      blk[w] = mem_m[d][wa];
    end
    @(negedge clk);
    start_s[d] = 1'b1; we_s[d] = we; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == 1) start_s[d] = 1'b0;
      if (inj && k == lat + 3) start_s[d] = 1'b0;
      busy = (k <= total);
      rdy  = (k == total);
      rv   = !we && (k > lat) && (k <= lat + 4);
      idx  = rv ? 2'(k - lat - 1) : 2'd0;
      data = rv ? blk[idx] : 32'd0;
      check(we ? "write_cycle" : "read_cycle", obs(d), pack(busy, rv, rdy, idx, data));
      if (inj && k == lat + 2) begin
        start_s[d] = 1'b1; we_s[d] = 1'b1; addr_s[d] = 10'h043; wdata_s[d] = 32'hFF;
      end
    end
    if (we) mem_m[d][a] = wd;
  endtask

  task automatic do_write(input int d, input logic [9:0] a, input logic [31:0] wd);
    do_req(d, 1'b1, a, wd, 1'b0);
  endtask

  task automatic do_read(input int d, input logic [9:0] a);
    do_req(d, 1'b0, a, 32'd0, 1'b0);
  endtask

  initial begin
    logic [9:0]  ra;
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0; start_s[d] = 1'b0; we_s[d] = 1'b0;
      addr_s[d] = '0; wdata_s[d] = '0;
    end

    // reset held for 3 cycles, then idle with start low
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("reset_out", obs(d), 64'd0);
    end
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("idle_after_reset", obs(d), 64'd0);
    end

    // write then read, both latencies
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 4; w++) do_write(d, 10'(10'h040 + w), 32'(32'hA0 + w));
      do_read(d, 10'h042);
    end

    // start pulsed mid-burst must be ignored
    do_req(0, 1'b0, 10'h041, 32'd0, 1'b1);
    do_read(0, 10'h043);
    do_req(1, 1'b0, 10'h041, 32'd0, 1'b1);
    do_read(1, 10'h043);

    // reset during the WAIT of a write
    for (int w = 0; w < 4; w++) do_write(0, 10'(10'h100 + w), 32'(32'h1234_0000 + w));
    @(negedge clk);
    start_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 10'h100; wdata_s[0] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    check("mid_wait_busy", obs(0), pack(1'b1, 1'b0, 1'b0, 2'd0, 32'd0));
    @(negedge clk);
    rst_s[0] = 1'b0;
    #1;
    check("async_reset_out", obs(0), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("in_reset_out", obs(0), 64'd0);
    end
    rst_s[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_ready_after_reset", obs(0), 64'd0);
    end
    do_read(0, 10'h100);
    do_read(0, 10'h040);

    // top of memory must not wrap into block 0
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 4; w++) begin
        do_write(d, 10'(w), 32'(32'hB000 + w));
        do_write(d, 10'(10'h3FC + w), 32'(32'hC000 + w));
      end
      do_read(d, 10'h3FE);
    end

    // randomized traffic over a small set of pre-filled blocks
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) do_write(d, 10'(10'h200 + w), $urandom);
      for (int n = 0; n < 20; n++) begin
        ra = 10'(10'h200 + $urandom_range(0, 15));
        rd = $urandom;
        if ($urandom_range(0, 1) == 1) do_write(d, ra, rd);
        else                           do_read(d, ra);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
